// File: rtl/fsm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_ctrl_pkg
// Brief    : Shared state encoding, mode codes and index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package fsm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_t;

    localparam int MODE_SEQ = 0;
    localparam int MODE_PAR = 1;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_group_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fsm_group_ctrl_if
// Brief    : Parent start/done handshake plus per-child go/done vectors.
// Revision : 1.0 - initial release
// ============================================================================
interface fsm_group_ctrl_if #(
    parameter int N_CHILD = 3
);
    localparam int IDX_W = fsm_ctrl_pkg::clog2_min1(N_CHILD);

    logic               valid;
    logic               ready;
    logic               busy;
    logic [IDX_W-1:0]   active_idx;
    logic [N_CHILD-1:0] child_valid;
    logic [N_CHILD-1:0] child_ready;

    modport master (
        output valid, child_ready,
        input  ready, busy, active_idx, child_valid
    );

    modport slave (
        input  valid, child_ready,
        output ready, busy, active_idx, child_valid
    );
endinterface
`default_nettype wire

// File: rtl/fsm_group_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fsm_group_ctrl
// Brief    : Runs N child controllers sequentially or in parallel, self-rearming.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_group_ctrl
    import fsm_ctrl_pkg::*;
#(
    parameter int N_CHILD = 3,
    parameter int MODE    = 0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fsm_group_ctrl_if.slave    bus
);

    localparam int IDX_W = clog2_min1(N_CHILD);

    if (N_CHILD < 1 || N_CHILD > 64 || MODE < 0 || MODE > 1) begin : g_param_check
        $error("fsm_group_ctrl: illegal N_CHILD or MODE");
    end

    ctrl_state_t        r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [N_CHILD-1:0] r_mask;
    logic [N_CHILD-1:0] r_child_valid;
    logic               r_ready;
    logic               r_busy;

    logic [N_CHILD-1:0] w_mask_next;
    logic [N_CHILD-1:0] w_cv_next;
    logic [IDX_W-1:0]   w_idx_next;
    logic               w_finish;

    // Only handshakes on children currently being driven count as done.
    assign w_mask_next = r_mask | (bus.child_ready & r_child_valid);

    if (MODE == MODE_SEQ) begin : g_seq
        logic w_hit;
        logic w_last;
        assign w_hit      = |(bus.child_ready & r_child_valid);
        assign w_last     = (r_idx == IDX_W'(N_CHILD - 1));
        assign w_finish   = w_hit & w_last;
        assign w_idx_next = w_hit ? (r_idx + IDX_W'(1)) : r_idx;
        assign w_cv_next  = N_CHILD'(1) << w_idx_next;
    end else begin : g_par
        assign w_finish   = &w_mask_next;
        assign w_idx_next = r_idx;
        assign w_cv_next  = ~w_mask_next;
    end

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_mask        <= '0;
            r_child_valid <= '0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.valid) begin
                        r_state       <= ST_RUN;
                        r_idx         <= '0;
                        r_mask        <= '0;
                        r_child_valid <= (MODE == MODE_PAR) ? {N_CHILD{1'b1}} : N_CHILD'(1);
                        r_busy        <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_mask <= w_mask_next;
                    r_idx  <= w_idx_next;
                    if (w_finish) begin
                        r_state       <= ST_DONE;
                        r_idx         <= r_idx;
                        r_child_valid <= '0;
                        r_ready       <= 1'b1;
                    end else begin
                        r_child_valid <= w_cv_next;
                    end
                end
                ST_DONE: begin
                    r_state       <= ST_IDLE;
                    r_idx         <= '0;
                    r_mask        <= '0;
                    r_child_valid <= '0;
                    r_ready       <= 1'b0;
                    r_busy        <= 1'b0;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_idx         <= '0;
                    r_mask        <= '0;
                    r_child_valid <= '0;
                    r_ready       <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.child_valid = r_child_valid;
    assign bus.ready       = r_ready;
    assign bus.busy        = r_busy;
    assign bus.active_idx  = (MODE == MODE_SEQ) ? r_idx : '0;

endmodule
`default_nettype wire

// File: tb/tb_fsm_group_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_group_ctrl
// Brief    : Bench for fsm_group_ctrl, sequential (N=3) and parallel (N=4) builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_group_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fsm_group_ctrl_if #(.N_CHILD(3)) if_s ();
    fsm_group_ctrl_if #(.N_CHILD(4)) if_p ();

    fsm_group_ctrl #(.N_CHILD(3), .MODE(0)) u_seq (.clk(clk), .reset(reset), .bus(if_s.slave));
    fsm_group_ctrl #(.N_CHILD(4), .MODE(1)) u_par (.clk(clk), .reset(reset), .bus(if_p.slave));

    int checks   = 0;
    int failures = 0;

    // Scenario: per-child latency (cycles between its go rising and its done).
    int   g_d [4];
    bit   g_par;
    logic [3:0] o_cv   [64];
    logic       o_rdy  [64];
    logic       o_busy [64];
    int         o_idx  [64];

    // Reference: each child owns a window of cycles; the group answers after the last window.
    function automatic void model(input int c, output logic [3:0] cv, output logic rdy,
                                  output logic bsy, output int idx, output int t_done);
        int t0;
        cv = '0; idx = 0;
        if (g_par) begin
            t_done = 0;
            for (int i = 0; i < 4; i++) begin
                if (g_d[i] + 1 > t_done) t_done = g_d[i] + 1;
                cv[i] = (c >= 1) && (c <= g_d[i] + 1);
            end
            t_done = t_done + 1;
        end else begin
            t0 = 1;
            for (int i = 0; i < 3; i++) begin
                if (c >= t0 && c <= t0 + g_d[i]) begin
                    cv[i] = 1'b1;
                    idx   = i;
                end
                t0 = t0 + g_d[i] + 1;
            end
            t_done = t0;
        end
        rdy = (c == t_done);
        bsy = (c >= 1) && (c <= t_done);
    endfunction

    // Pulses (or holds) valid, plays the children and records outputs per cycle.
    task automatic run_one(input bit par, input int ncyc, input bit hold_valid);
        int         cnt [4];
        logic [3:0] cv;
        logic [3:0] rd;
        int         n;
        n = par ? 4 : 3;
        cnt = '{default: 0};
        @(negedge clk);
        if (par) if_p.valid = 1'b1; else if_s.valid = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (!hold_valid) begin
                if_p.valid = 1'b0;
                if_s.valid = 1'b0;
            end
            cv        = par ? if_p.child_valid : {1'b0, if_s.child_valid};
            o_cv[c]   = cv;
            o_rdy[c]  = par ? if_p.ready : if_s.ready;
            o_busy[c] = par ? if_p.busy  : if_s.busy;
            o_idx[c]  = par ? int'(if_p.active_idx) : int'(if_s.active_idx);
            rd = '0;
            for (int i = 0; i < n; i++) begin
                if (cv[i]) begin
                    cnt[i] = cnt[i] + 1;
                    rd[i]  = (cnt[i] == g_d[i] + 1);
                end else begin
                    cnt[i] = 0;
                    rd[i]  = 1'($urandom_range(0, 1));
                end
            end
            if (par) if_p.child_ready = rd; else if_s.child_ready = rd[2:0];
        end
        if_p.valid = 1'b0; if_s.valid = 1'b0;
        if_p.child_ready = '0; if_s.child_ready = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_s.valid = 1'b0; if_p.valid = 1'b0;
        if_s.child_ready = '0; if_p.child_ready = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if_s.child_ready = 3'($urandom_range(0, 7));
            if_p.child_ready = 4'($urandom_range(0, 15));
            @(negedge clk);
            checks++;
            if ({if_s.child_valid, if_s.ready, if_s.busy, if_s.active_idx} !== 7'b0) begin
                failures++;
                $display("FAIL reset_idle_seq cyc=%0d got cv=%b rdy=%b busy=%b idx=%0d exp all 0",
                         c, if_s.child_valid, if_s.ready, if_s.busy, if_s.active_idx);
            end
            checks++;
            if ({if_p.child_valid, if_p.ready, if_p.busy, if_p.active_idx} !== 8'b0) begin
                failures++;
                $display("FAIL reset_idle_par cyc=%0d got cv=%b rdy=%b busy=%b idx=%0d exp all 0",
                         c, if_p.child_valid, if_p.ready, if_p.busy, if_p.active_idx);
            end
        end
        if_s.child_ready = '0; if_p.child_ready = '0;
    endtask

    task automatic test_sequential();
        logic [3:0] e_cv; logic e_rdy, e_bsy; int e_idx, t_done, ncyc;
        for (int s = 0; s < 6; s++) begin
            case (s)
                0:       g_d = '{0, 0, 0, 0};
                1:       g_d = '{0, 4, 0, 0};
                default: for (int i = 0; i < 4; i++) g_d[i] = $urandom_range(0, 5);
            endcase
            g_par = 1'b0;
            ncyc = g_d[0] + g_d[1] + g_d[2] + 6;
            run_one(1'b0, ncyc, 1'b0);
            for (int c = 1; c <= ncyc; c++) begin
                model(c, e_cv, e_rdy, e_bsy, e_idx, t_done);
                checks++;
                if (o_cv[c] !== e_cv || o_rdy[c] !== e_rdy || o_busy[c] !== e_bsy
                    || (c != t_done && o_idx[c] != e_idx)) begin
                    failures++;
                    $display("FAIL seq set=%0d cyc=%0d got cv=%b rdy=%b busy=%b idx=%0d exp cv=%b rdy=%b busy=%b idx=%0d",
                             s, c, o_cv[c], o_rdy[c], o_busy[c], o_idx[c], e_cv, e_rdy, e_bsy, e_idx);
                end
            end
        end
    endtask

    task automatic test_parallel();
        logic [3:0] e_cv; logic e_rdy, e_bsy; int e_idx, t_done, ncyc;
        for (int s = 0; s < 6; s++) begin
            case (s)
                0:       g_d = '{2, 0, 0, 4};
                1:       g_d = '{0, 0, 0, 0};
                default: for (int i = 0; i < 4; i++) g_d[i] = $urandom_range(0, 6);
            endcase
            g_par = 1'b1;
            ncyc = 10;
            run_one(1'b1, ncyc, 1'b0);
            for (int c = 1; c <= ncyc; c++) begin
                model(c, e_cv, e_rdy, e_bsy, e_idx, t_done);
                checks++;
                if (o_cv[c] !== e_cv || o_rdy[c] !== e_rdy || o_busy[c] !== e_bsy || o_idx[c] != 0) begin
                    failures++;
                    $display("FAIL par set=%0d cyc=%0d got cv=%b rdy=%b busy=%b idx=%0d exp cv=%b rdy=%b busy=%b idx=0",
                             s, c, o_cv[c], o_rdy[c], o_busy[c], o_idx[c], e_cv, e_rdy, e_bsy);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_cv; int ph, pulses;
        g_d = '{0, 0, 0, 0};
        g_par = 1'b0;
        run_one(1'b0, 11, 1'b1);
        pulses = 0;
        for (int c = 1; c <= 11; c++) begin
            ph = c % 5;
            e_cv = (ph >= 1 && ph <= 3) ? (4'b0001 << (ph - 1)) : 4'b0000;
            if (o_rdy[c] === 1'b1) pulses++;
            checks++;
            if (o_cv[c] !== e_cv || o_rdy[c] !== (ph == 4) || o_busy[c] !== (ph != 0)) begin
                failures++;
                $display("FAIL b2b cyc=%0d got cv=%b rdy=%b busy=%b exp cv=%b rdy=%b busy=%b",
                         c, o_cv[c], o_rdy[c], o_busy[c], e_cv, (ph == 4), (ph != 0));
            end
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d exp=2", pulses);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if_s.valid = 1'b1;
        @(negedge clk);
        if_s.valid = 1'b0;
        checks++;
        if (if_s.child_valid !== 3'b001 || if_s.active_idx !== 2'd0) begin
            failures++;
            $display("FAIL midrst_start got cv=%b idx=%0d exp cv=001 idx=0", if_s.child_valid, if_s.active_idx);
        end
        if_s.child_ready = 3'b001;
        @(negedge clk);
        if_s.child_ready = 3'b000;
        checks++;
        if (if_s.child_valid !== 3'b010 || if_s.active_idx !== 2'd1) begin
            failures++;
            $display("FAIL midrst_idx1 got cv=%b idx=%0d exp cv=010 idx=1", if_s.child_valid, if_s.active_idx);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({if_s.child_valid, if_s.ready, if_s.busy, if_s.active_idx} !== 7'b0) begin
            failures++;
            $display("FAIL midrst_idle got cv=%b rdy=%b busy=%b idx=%0d exp all 0",
                     if_s.child_valid, if_s.ready, if_s.busy, if_s.active_idx);
        end
        reset = 1'b0;
        if_s.valid = 1'b1;
        @(negedge clk);
        if_s.valid = 1'b0;
        checks++;
        if (if_s.child_valid !== 3'b001 || if_s.active_idx !== 2'd0 || if_s.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_restart got cv=%b idx=%0d busy=%b exp cv=001 idx=0 busy=1",
                     if_s.child_valid, if_s.active_idx, if_s.busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_parallel();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_group_ctrl.md
Name: fsm_group_ctrl

Overview:
- Generalised control FSM for a group of N child controllers, each with a valid/ready (go/done) interface.
- MODE selects sequential execution (children one after another, in index order) or parallel execution (all children started together, join on all done).
- Replaces the per-group fixed-width enable/seq FSMs with one parametrised block.
- Unlike those FSMs, it returns to IDLE by itself after signalling completion, so the group can be re-run without a reset.

Parameters:
- N_CHILD, 3, number of child controllers; legal range 1..64.
- MODE, 0, 0 = sequential, 1 = parallel.
- IDX_W (localparam), max(1, $clog2(N_CHILD)), width of the child index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  start request from the parent; sampled only in IDLE.
- child_ready  in  N_CHILD  per-child done; bit i is honoured only while child_valid[i]=1.
- child_valid  out  N_CHILD  per-child go.
- ready  out  1  group done; one-cycle pulse.
- busy  out  1  high in RUN and DONE.
- active_idx  out  IDX_W  current child in sequential mode; 0 in parallel mode and in IDLE.

Behaviour:
- Reset
  - On any edge with reset=1: state<=IDLE, idx<=0, done_mask<=0.
  - Takes priority over every other event, including mid-RUN and in DONE.
  - While in IDLE, all outputs are 0: child_valid=0, ready=0, busy=0, active_idx=0.
- States: IDLE, RUN, DONE. Outputs are Moore, decoded from registered state, idx and done_mask.
- IDLE
  - valid=1 at an edge -> RUN, with idx<=0 and done_mask<=0.
  - valid=0 -> stay in IDLE.
- RUN, sequential mode (MODE=0)
  - Outputs: child_valid = one-hot(idx); active_idx = idx.
  - Edge with child_ready[idx]=1 and idx<N_CHILD-1 -> idx<=idx+1. The next child's valid rises in the following cycle, with no bubble cycle.
  - Edge with child_ready[idx]=1 and idx=N_CHILD-1 -> DONE.
  - child_ready bits for other indices are ignored.
- RUN, parallel mode (MODE=1)
  - Outputs: child_valid = ~done_mask. Each child's valid drops the cycle after its ready is seen.
  - At each edge: done_mask <= done_mask | (child_ready & child_valid).
  - If the updated mask is all ones -> DONE. This covers several, or all, children finishing on the same edge.
- DONE
  - Outputs: ready=1, child_valid=0, busy=1 for exactly one cycle.
  - Next edge: unconditionally -> IDLE.
  - valid asserted during DONE is ignored. A restart is accepted no earlier than the edge following the first IDLE cycle.
- valid is not required to be held during RUN; deasserting it has no effect.
- child_ready bits arriving while the matching child_valid=0 (including in IDLE and DONE) are ignored.
- Latency with every child answering ready in the first cycle of its valid:
  - sequential: valid sampled at edge 0; ready high in cycle N_CHILD+1.
  - parallel: ready high in cycle 2.
- N_CHILD=1: both modes behave identically; active_idx is 1 bit, always 0.
- Illegal parameter values (N_CHILD<1, MODE>1) are rejected by an elaboration-time assertion.

Decomposition:
- Shared package fsm_ctrl_pkg:
  - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ctrl_state_t
  - localparams MODE_SEQ=0, MODE_PAR=1
  - function clog2_min1 for IDX_W
- No sub-module: the sequential and parallel datapaths are small generate branches inside one module sharing the state register.

Test Plan:
- Reset, then idle: with valid=0 for 5 cycles, child_valid=0, ready=0 and busy=0 throughout.
- MODE=0, N_CHILD=3, zero-delay children:
  - valid pulsed at cycle 0.
  - child_valid = 001, 010, 100 in cycles 1, 2, 3.
  - ready=1 in cycle 4 only; IDLE in cycle 5.
- MODE=0, N_CHILD=3, child 1 stalls 4 cycles:
  - child_valid=010 held for 5 cycles, with active_idx=1.
  - A spurious child_ready[2] during that window is ignored.
  - ready arrives 4 cycles later than in the zero-delay case.
- MODE=1, N_CHILD=4, children done at relative cycles 3, 1, 1, 5:
  - child_valid sequence 1111 -> 1001 -> 1000 ...
  - ready pulses the cycle after child 3's ready.
  - Also check with all four done on the same edge: ready in cycle 2.
- Back-to-back runs: valid held high continuously. ready pulses, one IDLE cycle follows, then the next RUN starts. Two complete runs must be observed with no reset in between.
- Mid-run reset: MODE=0, assert reset while idx=1. The next cycle has all outputs 0 in IDLE. A subsequent valid starts again at child 0.
